intdiv_radix2: RTL and testbench

Iterative radix-2 restoring integer divider that serves the M-extension unit's divide requests. It accepts a divide/remainder request in Execute and holds the pipeline with a busy signal while it iterates. It then presents the quotient and remainder to the Memory-stage result mux, implementing RISC-V DIV/DIVU/REM/REMU and, for XLEN=64, DIVW/DIVUW/REMW/REMUW.

---
 rtl/intdiv_radix2.sv | 129 ++++++++++++
 tb/tb_intdiv_radix2.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intdiv_radix2.sv
`default_nettype none
// ============================================================================
// Module   : intdiv_radix2
// Brief    : Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU(W).
// Revision : 1.0 - initial release
// ============================================================================
module intdiv_radix2 #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallM,
    input  logic            FlushE,
    input  logic            IntDivE,
    input  logic            DivSignedE,
    input  logic            W64E,
    input  logic [XLEN-1:0] ForwardedSrcAE,
    input  logic [XLEN-1:0] ForwardedSrcBE,
    output logic            DivBusyE,
    output logic [XLEN-1:0] QuotM,
    output logic [XLEN-1:0] RemM
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            w_start, w_w64, w_sign_a, w_sign_b, w_last;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_abs_a, w_abs_b;
    logic [XLEN-1:0] r_rem, r_quot, r_abs_b;
    logic            r_sign_a, r_sign_b, r_w64, r_bzero;
    logic [CW-1:0]   r_cnt, w_last_idx;
    logic [XLEN:0]   w_shift, w_diff;
    logic [XLEN-1:0] w_rem_nxt, w_quot_nxt, w_q_res, w_r_res;

    // Operand preparation: W-type ops work on the low word, extended by signedness
    always_comb begin
        w_w64 = (XLEN == 64) && W64E;
        if (w_w64) begin
            w_a_ext = DivSignedE ? XLEN'($signed(ForwardedSrcAE[31:0])) : XLEN'(ForwardedSrcAE[31:0]);
            w_b_ext = DivSignedE ? XLEN'($signed(ForwardedSrcBE[31:0])) : XLEN'(ForwardedSrcBE[31:0]);
            w_sign_a = DivSignedE & ForwardedSrcAE[31];
            w_sign_b = DivSignedE & ForwardedSrcBE[31];
        end else begin
            w_a_ext  = ForwardedSrcAE;
            w_b_ext  = ForwardedSrcBE;
            w_sign_a = DivSignedE & ForwardedSrcAE[XLEN-1];
            w_sign_b = DivSignedE & ForwardedSrcBE[XLEN-1];
        end
        w_abs_a = w_sign_a ? -w_a_ext : w_a_ext;
        w_abs_b = w_sign_b ? -w_b_ext : w_b_ext;
    end

    // One restoring step: shift in next dividend bit, trial-subtract the divisor
    always_comb begin
        w_shift    = {r_rem, r_quot[XLEN-1]};
        w_diff     = w_shift - {1'b0, r_abs_b};
        w_rem_nxt  = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
        w_quot_nxt = {r_quot[XLEN-2:0], ~w_diff[XLEN]};
        w_q_res    = ((r_sign_a ^ r_sign_b) & ~r_bzero) ? -w_quot_nxt : w_quot_nxt;
        w_r_res    = r_sign_a ? -w_rem_nxt : w_rem_nxt;
        if (r_w64) begin
            w_q_res = XLEN'($signed(w_q_res[31:0]));
            w_r_res = XLEN'($signed(w_r_res[31:0]));
        end
        w_last_idx = r_w64 ? CW'(31) : CW'(XLEN - 1);
        w_last     = (r_cnt == w_last_idx);
    end

    always_comb begin
        w_start     = IntDivE & (r_state == S_IDLE) & ~FlushE & ~StallM;
        DivBusyE    = w_start | (r_state == S_BUSY);
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
            S_BUSY: begin
                if (FlushE)      w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE:  if (FlushE || !StallM) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem    <= '0;
            r_quot   <= '0;
            r_abs_b  <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_w64    <= 1'b0;
            r_bzero  <= 1'b0;
            r_cnt    <= '0;
            QuotM    <= '0;
            RemM     <= '0;
        end else if (w_start) begin
            r_rem    <= '0;
            // Left-align a W-type dividend so bits always enter from the top
            r_quot   <= w_w64 ? (w_abs_a << (XLEN - 32)) : w_abs_a;
            r_abs_b  <= w_abs_b;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_w64    <= w_w64;
            r_bzero  <= (w_b_ext == '0);
            r_cnt    <= '0;
        end else if (r_state == S_BUSY && !FlushE) begin
            r_rem  <= w_rem_nxt;
            r_quot <= w_quot_nxt;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
                QuotM <= w_q_res;
                RemM  <= w_r_res;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_intdiv_radix2.sv
`default_nettype none
// ============================================================================
// Module   : tb_intdiv_radix2
// Brief    : Self-checking bench for intdiv_radix2 (XLEN=64) with arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intdiv_radix2;

    logic        clk = 1'b0;
    logic        reset, StallM, FlushE, IntDivE, DivSignedE, W64E;
    logic [63:0] ForwardedSrcAE, ForwardedSrcBE;
    logic        DivBusyE;
    logic [63:0] QuotM, RemM;

    int n_cmp  = 0;
    int n_fail = 0;

    intdiv_radix2 #(.XLEN(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .StallM         (StallM),
        .FlushE         (FlushE),
        .IntDivE        (IntDivE),
        .DivSignedE     (DivSignedE),
        .W64E           (W64E),
        .ForwardedSrcAE (ForwardedSrcAE),
        .ForwardedSrcBE (ForwardedSrcBE),
        .DivBusyE       (DivBusyE),
        .QuotM          (QuotM),
        .RemM           (RemM)
    );

    always #5 clk = ~clk;

    // RISC-V division semantics straight from the ISA rules
    function automatic void ref_div(input logic [63:0] a, input logic [63:0] b,
                                    input bit sgn, input bit w,
                                    output logic [63:0] q, output logic [63:0] r);
        logic [31:0] a32, b32, q32, r32;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 32'd0) begin
                q32 = '1; r32 = a32;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 32'd0;
            end else if (sgn) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) begin
                q = '1; r = a;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = 64'd0;
            end else if (sgn) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    // Issue one divide and follow it to the Memory stage.
    task automatic do_div(input logic [63:0] a, input logic [63:0] b, input bit sgn, input bit w,
                          output logic [63:0] q, output logic [63:0] r,
                          output int busy, output logic [63:0] q_at_start);
        bit done;
        ForwardedSrcAE = a;
        ForwardedSrcBE = b;
        DivSignedE     = sgn;
        W64E           = w;
        IntDivE        = 1'b1;
        busy = 0;
        done = 1'b0;
        #1;
        q_at_start = QuotM;
        for (int i = 0; i < 100 && !done; i++) begin
            if (DivBusyE) begin
                busy++;
                @(negedge clk); #1;
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL busy_timeout: DivBusyE still high after %0d cycles, required drop", busy);
        end
        IntDivE = 1'b0;
        @(negedge clk); #1;
        q = QuotM;
        r = RemM;
    endtask

    task automatic check_div(input string name, input logic [63:0] a, input logic [63:0] b,
                             input bit sgn, input bit w);
        logic [63:0] q, r, eq, er, qs;
        int busy;
        ref_div(a, b, sgn, w, eq, er);
        do_div(a, b, sgn, w, q, r, busy, qs);
        n_cmp++;
        if (q !== eq || r !== er || busy !== (w ? 33 : 65)) begin
            n_fail++;
            $display("FAIL %s: a=%h b=%h s=%0d w=%0d got q=%h r=%h busy=%0d, required q=%h r=%h busy=%0d",
                     name, a, b, sgn, w, q, r, busy, eq, er, (w ? 33 : 65));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; StallM = 1'b0; FlushE = 1'b0; IntDivE = 1'b0;
        DivSignedE = 1'b0; W64E = 1'b0; ForwardedSrcAE = '0; ForwardedSrcBE = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (QuotM !== 64'd0 || RemM !== 64'd0 || DivBusyE !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got q=%h r=%h busy=%b, required 0 0 0", QuotM, RemM, DivBusyE);
        end
    endtask

    task automatic test_directed();
        logic [63:0] q, r, qs;
        int busy;
        do_div(64'd100, 64'd7, 1'b0, 1'b0, q, r, busy, qs);
        n_cmp++;
        if (q !== 64'd14 || r !== 64'd2 || busy !== 65) begin
            n_fail++;
            $display("FAIL divu_100_7: got q=%0d r=%0d busy=%0d, required 14 2 65", q, r, busy);
        end
        do_div(-64'sd100, 64'd7, 1'b1, 1'b0, q, r, busy, qs);
        n_cmp++;
        if (q !== 64'hFFFF_FFFF_FFFF_FFF2 || r !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            n_fail++;
            $display("FAIL div_neg100_7: got q=%h r=%h, required -14 -2", q, r);
        end
        do_div(64'hFFFF_FFFF_8000_0000, '1, 1'b1, 1'b1, q, r, busy, qs);
        n_cmp++;
        if (q !== 64'hFFFF_FFFF_8000_0000 || r !== 64'd0 || busy !== 33) begin
            n_fail++;
            $display("FAIL divw_overflow: got q=%h r=%h busy=%0d, required ffffffff80000000 0 33", q, r, busy);
        end
        do_div(-64'sd5, 64'd0, 1'b1, 1'b0, q, r, busy, qs);
        n_cmp++;
        if (q !== '1 || r !== 64'hFFFF_FFFF_FFFF_FFFB) begin
            n_fail++;
            $display("FAIL div_by_zero: got q=%h r=%h, required all-ones -5", q, r);
        end
        do_div(64'h1_2345_6789, 64'd0, 1'b0, 1'b1, q, r, busy, qs);
        n_cmp++;
        if (r !== 64'h0000_0000_2345_6789 || q !== '1) begin
            n_fail++;
            $display("FAIL remuw_by_zero: got q=%h r=%h, required all-ones 0000000023456789", q, r);
        end
        do_div(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, q, r, busy, qs);
        n_cmp++;
        if (q !== 64'h8000_0000_0000_0000 || r !== 64'd0) begin
            n_fail++;
            $display("FAIL div_overflow64: got q=%h r=%h, required 8000000000000000 0", q, r);
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b;
        bit sgn, w;
        for (int i = 0; i < 24; i++) begin
            a   = {$urandom, $urandom};
            sgn = 1'($urandom_range(0, 1));
            w   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       b = {$urandom, $urandom};
                1:       b = 64'($urandom_range(1, 15));
                2:       b = 64'd0;
                3:       begin b = '1; a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000; end
                default: b = {32'hFFFF_FFFF, $urandom};
            endcase
            check_div("random", a, b, sgn, w);
        end
    endtask

    task automatic test_flush();
        logic [63:0] q0, r0, q, r, qs;
        int busy;
        q0 = QuotM; r0 = RemM;
        ForwardedSrcAE = 64'd123456; ForwardedSrcBE = 64'd11;
        DivSignedE = 1'b0; W64E = 1'b0; IntDivE = 1'b1;
        repeat (10) @(negedge clk);
        FlushE = 1'b1; IntDivE = 1'b0;
        #1;
        n_cmp++;
        if (DivBusyE !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_busy_c10: got busy=%b, required 1", DivBusyE);
        end
        @(negedge clk);
        FlushE = 1'b0;
        #1;
        n_cmp++;
        if (DivBusyE !== 1'b0 || QuotM !== q0 || RemM !== r0) begin
            n_fail++;
            $display("FAIL flush_abort: got busy=%b q=%h r=%h, required 0 %h %h", DivBusyE, QuotM, RemM, q0, r0);
        end
        do_div(64'd9, 64'd3, 1'b0, 1'b0, q, r, busy, qs);
        n_cmp++;
        if (q !== 64'd3 || r !== 64'd0 || busy !== 65) begin
            n_fail++;
            $display("FAIL after_flush: got q=%0d r=%0d busy=%0d, required 3 0 65", q, r, busy);
        end
    endtask

    task automatic test_stall();
        logic [63:0] q, r, qs;
        int busy;
        // Start deferred while M is stalled
        ForwardedSrcAE = 64'd50; ForwardedSrcBE = 64'd8;
        DivSignedE = 1'b0; W64E = 1'b0; IntDivE = 1'b1; StallM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (DivBusyE !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_defer: got busy=%b, required 0", DivBusyE);
            end
            @(negedge clk);
        end
        StallM = 1'b0;
        #1;
        busy = 0;
        for (int i = 0; i < 100 && DivBusyE; i++) begin
            busy++;
            @(negedge clk); #1;
        end
        n_cmp++;
        if (busy !== 65) begin
            n_fail++;
            $display("FAIL stall_busy_len: got %0d, required 65", busy);
        end
        // Now in DONE; hold M stalled with the request still asserted
        StallM = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (DivBusyE !== 1'b0 || QuotM !== 64'd6 || RemM !== 64'd2) begin
                n_fail++;
                $display("FAIL stall_done: got busy=%b q=%0d r=%0d, required 0 6 2", DivBusyE, QuotM, RemM);
            end
        end
        @(negedge clk);
        StallM = 1'b0;
        #1;
        n_cmp++;
        if (DivBusyE !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_no_restart: got busy=%b, required 0", DivBusyE);
        end
        @(negedge clk);
        IntDivE = 1'b0;
        #1;
        do_div(64'd20, 64'd6, 1'b0, 1'b0, q, r, busy, qs);
        n_cmp++;
        if (q !== 64'd3) begin
            n_fail++;
            $display("FAIL b2b_first_q: got %0d, required 3", q);
        end
        do_div(64'd20, 64'd6, 1'b0, 1'b0, q, r, busy, qs);
        n_cmp++;
        if (qs !== 64'd3 || r !== 64'd2 || busy !== 65) begin
            n_fail++;
            $display("FAIL b2b_second: got q_at_start=%0d r=%0d busy=%0d, required 3 2 65", qs, r, busy);
        end
    endtask

    task automatic test_reset_mid();
        ForwardedSrcAE = 64'd777; ForwardedSrcBE = 64'd5;
        DivSignedE = 1'b0; W64E = 1'b0; IntDivE = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b1; IntDivE = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (DivBusyE !== 1'b0 || QuotM !== 64'd0 || RemM !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b q=%h r=%h, required 0 0 0", DivBusyE, QuotM, RemM);
        end
        reset = 1'b0;
        @(negedge clk); #1;
        check_div("after_reset", 64'd777, 64'd5, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
